// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end: pin synchronisers, SCLK/CS edge detection,
// MOSI deserialiser, MISO serialiser with one-word holding buffer.
//
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   sclk_pin, cs_n_pin,
//   mosi_pin               raw SPI pins from the master
//   tx_data/tx_valid/
//   tx_ready               holding-buffer write handshake
//   rx_data/rx_valid       last completed word and its update pulse
//   miso_bit/miso_we       data and write enable for the external MISO flop
//   tx_underrun            word started with an empty holding buffer
//   busy                   synchronised chip select is asserted

module spi_slave_shifter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sclk_pin,
    input  logic             cs_n_pin,
    input  logic             mosi_pin,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             miso_bit,
    output logic             miso_we,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_cs_hist;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_word_done;
    logic [WIDTH-1:0]       r_buf;
    logic                   r_buf_full;
    logic                   r_tx_ready;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso_we;
    logic                   r_tx_underrun;
    logic                   r_busy;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_drain;
    logic [WIDTH-1:0]       w_shift_in;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_hist;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_hist;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_hist;
    assign w_shift_in  = {r_shift[WIDTH-2:0], w_mosi_s};

    // A word starts on CS assertion, or on the first falling SCLK edge
    // after a completed word while CS stays low.
    assign w_start  = ((r_state == IDLE) && w_cs_fall) ||
                      ((r_state == ACTIVE) && !w_cs_rise &&
                       !w_sclk_rise && w_sclk_fall && r_word_done);
    assign w_accept = tx_valid && r_tx_ready;
    assign w_drain  = w_start && r_buf_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            r_sclk_hist <= w_sclk_s;
            r_cs_hist   <= w_cs_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_tx_ready    <= 1'b1;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_miso_we     <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_miso_we     <= 1'b0;
            r_tx_underrun <= 1'b0;

            // Accept and drain are exclusive: accept needs an empty
            // buffer, drain needs a full one.
            if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
                r_tx_ready <= 1'b0;
            end else if (w_drain) begin
                r_buf_full <= 1'b0;
                r_tx_ready <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state     <= ACTIVE;
                        r_busy      <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_in;
                        if (r_bit_cnt == LAST) begin
                            r_rx_data   <= w_shift_in;
                            r_rx_valid  <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall && !r_word_done) begin
                        r_miso_we <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_start) begin
                r_shift       <= r_buf_full ? r_buf : '0;
                r_tx_underrun <= ~r_buf_full;
                r_miso_we     <= 1'b1;
                r_word_done   <= 1'b0;
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign miso_bit    = r_shift[WIDTH-1];
    assign miso_we     = r_miso_we;
    assign tx_underrun = r_tx_underrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: mode-0 master model driving the
// pins, external MISO flop model, event counters and immediate assertions.

module tb_spi_slave_shifter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk_pin = 1'b0;
    logic       cs_n_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       miso_bit;
    logic       miso_we;
    logic       tx_underrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int n_we  = 0;
    int n_rxv = 0;
    int n_und = 0;
    logic miso_q = 1'b0;

    spi_slave_shifter #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk_pin   (sclk_pin),
        .cs_n_pin   (cs_n_pin),
        .mosi_pin   (mosi_pin),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .miso_bit   (miso_bit),
        .miso_we    (miso_we),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream MISO flop the design's miso_we is meant to drive.
    always @(posedge clk)
        if (miso_we) miso_q <= miso_bit;

    always @(negedge clk) begin
        if (miso_we)     n_we++;
        if (rx_valid)    n_rxv++;
        if (tx_underrun) n_und++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode 0: MOSI changes with SCLK low, both sides sample on the rise.
    // SCLK is left high after the last bit.
    task automatic xfer(input logic [7:0] m, input int nbits,
                        output logic [7:0] s);
        s = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sclk_pin = 1'b0;
            mosi_pin = m[i];
            wait_n(4);
            s[i] = miso_q;
            sclk_pin = 1'b1;
            wait_n(4);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n_pin = 1'b0;
        wait_n(8);
    endtask

    task automatic end_frame();
        sclk_pin = 1'b0;
        cs_n_pin = 1'b1;
        wait_n(6);
    endtask

    initial begin
        logic [7:0] got;
        int we0, rxv0, und0;

        wait_n(3);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_miso_bit", miso_bit, 0);
        chk("rst_miso_we", miso_we, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        reset_n = 1'b1;
        wait_n(3);

        // Frame 1: tx A5, rx 3C.
        push(8'hA5);
        chk("f1_ready_low", tx_ready, 0);
        we0 = n_we; rxv0 = n_rxv; und0 = n_und;
        cs_low();
        chk("f1_busy", busy, 1);
        chk("f1_ready_drained", tx_ready, 1);
        xfer(8'h3C, 8, got);
        chk("f1_rx", rx_data, 8'h3C);
        chk("f1_miso", got, 8'hA5);
        chk("f1_rxv_cnt", n_rxv - rxv0, 1);
        chk("f1_we_cnt", n_we - we0, 8);
        chk("f1_und_cnt", n_und - und0, 0);
        end_frame();
        chk("f1_idle", busy, 0);

        // Frame 2: back-to-back words under one CS.
        push(8'h01);
        rxv0 = n_rxv; und0 = n_und;
        cs_low();
        chk("f2_ready_a", tx_ready, 1);
        push(8'h80);
        chk("f2_ready_b", tx_ready, 0);
        xfer(8'hFF, 8, got);
        chk("f2_rx_a", rx_data, 8'hFF);
        chk("f2_miso_a", got, 8'h01);
        xfer(8'h00, 8, got);
        chk("f2_rx_b", rx_data, 8'h00);
        chk("f2_miso_b", got, 8'h80);
        chk("f2_ready_c", tx_ready, 1);
        chk("f2_rxv_cnt", n_rxv - rxv0, 2);
        chk("f2_und_cnt", n_und - und0, 0);
        end_frame();

        // Frame 3: empty buffer at CS fall.
        rxv0 = n_rxv; und0 = n_und;
        cs_low();
        xfer(8'h69, 8, got);
        chk("f3_und_cnt", n_und - und0, 1);
        chk("f3_miso", got, 8'h00);
        chk("f3_rx", rx_data, 8'h69);
        chk("f3_rxv_cnt", n_rxv - rxv0, 1);
        end_frame();

        // Frame 4: abort after 5 bits, then a full frame.
        rxv0 = n_rxv;
        cs_low();
        xfer(8'hF0, 5, got);
        @(negedge clk);
        sclk_pin = 1'b0;
        cs_n_pin = 1'b1;
        wait_n(2);
        chk("f4_busy_still", busy, 1);
        wait_n(1);
        chk("f4_busy_low", busy, 0);
        wait_n(4);
        chk("f4_rx_hold", rx_data, 8'h69);
        chk("f4_rxv_cnt", n_rxv - rxv0, 0);
        push(8'h96);
        cs_low();
        xfer(8'h5A, 8, got);
        chk("f4_rx_next", rx_data, 8'h5A);
        chk("f4_miso_next", got, 8'h96);
        end_frame();

        // SCLK activity with CS high is ignored.
        we0 = n_we; rxv0 = n_rxv;
        for (int k = 0; k < 10; k++) begin
            sclk_pin = ~sclk_pin;
            mosi_pin = ~mosi_pin;
            wait_n(4);
        end
        sclk_pin = 1'b0;
        wait_n(4);
        chk("idle_we_cnt", n_we - we0, 0);
        chk("idle_rxv_cnt", n_rxv - rxv0, 0);
        chk("idle_miso_bit", miso_bit, 0);
        chk("idle_busy", busy, 0);

        // Reset mid-word, then a clean frame.
        push(8'hE7);
        cs_low();
        xfer(8'hAA, 3, got);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", tx_ready, 1);
        chk("mrst_rx", rx_data, 8'h00);
        chk("mrst_rxv", rx_valid, 0);
        chk("mrst_miso", miso_bit, 0);
        chk("mrst_we", miso_we, 0);
        chk("mrst_und", tx_underrun, 0);
        sclk_pin = 1'b0;
        cs_n_pin = 1'b1;
        mosi_pin = 1'b0;
        wait_n(3);
        reset_n = 1'b1;
        wait_n(3);
        push(8'h3C);
        rxv0 = n_rxv;
        cs_low();
        xfer(8'hC3, 8, got);
        chk("post_rx", rx_data, 8'hC3);
        chk("post_miso", got, 8'h3C);
        chk("post_rxv_cnt", n_rxv - rxv0, 1);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
